// File: rtl/fetch_queue_unit_if.sv
// rtl/fetch_queue_unit_if.sv - memory, predictor and dequeue signals of the fetch queue unit
interface fetch_queue_unit_if #(
    parameter int unsigned DEPTH_LOG2 = 4
);
    logic [31:0]         pred_pc_req_out;
    logic                pred_taken_in;
    logic                mem_req_out;
    logic [31:0]         mem_addr_out;
    logic                mem_valid_in;
    logic [7:0]          mem_din_in;
    logic                deq_ready_in;
    logic                deq_valid_out;
    logic [31:0]         deq_instr_out;
    logic [31:0]         deq_pc_out;
    logic [31:0]         deq_pred_pc_out;
    logic [DEPTH_LOG2:0] count_out;

    modport master (
        output pred_pc_req_out, mem_req_out, mem_addr_out, deq_valid_out,
               deq_instr_out, deq_pc_out, deq_pred_pc_out, count_out,
        input  pred_taken_in, mem_valid_in, mem_din_in, deq_ready_in
    );

    modport slave (
        input  pred_pc_req_out, mem_req_out, mem_addr_out, deq_valid_out,
               deq_instr_out, deq_pc_out, deq_pred_pc_out, count_out,
        output pred_taken_in, mem_valid_in, mem_din_in, deq_ready_in
    );
endinterface

// File: rtl/fetch_queue_unit.sv
// rtl/fetch_queue_unit.sv - byte-serial instruction fetch, next-PC prediction and decode FIFO
// Optional performance counters are built when FETCH_PERF_EN is defined.
module fetch_queue_unit #(
    parameter int unsigned DEPTH_LOG2   = 4,
    parameter int unsigned AFULL_MARGIN = 1,
    parameter logic [31:0] RESET_PC     = 32'h0
) (
    input  logic                clk_in,
    input  logic                rst_n_in,
    input  logic                rdy_in,
    input  logic                redirect_in,
    input  logic [31:0]         redirect_pc_in,
    fetch_queue_unit_if.master  fq
`ifdef FETCH_PERF_EN
    ,
    output logic [31:0]         perf_fetched_out,
    output logic [31:0]         perf_flush_out,
    output logic [31:0]         perf_stall_out
`endif
);
    localparam int unsigned       DEPTH  = 1 << DEPTH_LOG2;
    localparam int unsigned       CW     = DEPTH_LOG2 + 1;
    localparam logic [CW-1:0]     THRESH = CW'(DEPTH - AFULL_MARGIN);
    localparam logic [6:0]        OP_JAL = 7'b1101111;
    localparam logic [6:0]        OP_BR  = 7'b1100011;

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT} state_t;

    state_t                state_q, state_d;
    logic [31:0]           fetch_pc_q;
    logic [1:0]            byte_cnt_q;
    logic [1:0]            rcv_cnt_q;
    logic [23:0]           instr_buf_q;
    logic                  discard_q;
    logic [DEPTH_LOG2-1:0] wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]         count_q;
    logic [95:0]           fifo_mem [DEPTH];

    logic        can_start, mem_req, byte_take, push, pop, deq_valid;
    logic [31:0] instr_full, j_off, b_off, pred_pc;
    logic [95:0] head;

    assign can_start  = count_q < THRESH;
    assign mem_req    = rdy_in && (state_q == S_REQ);
    assign byte_take  = rdy_in && !redirect_in && fq.mem_valid_in && !discard_q;
    assign push       = byte_take && (rcv_cnt_q == 2'd3);
    assign deq_valid  = count_q != '0;
    assign pop        = rdy_in && !redirect_in && fq.deq_ready_in && deq_valid;

    // The last byte is used straight from the bus so the push needs no extra cycle.
    assign instr_full = {fq.mem_din_in, instr_buf_q};
    assign j_off = {{11{instr_full[31]}}, instr_full[31], instr_full[19:12],
                    instr_full[20], instr_full[30:21], 1'b0};
    assign b_off = {{19{instr_full[31]}}, instr_full[31], instr_full[7],
                    instr_full[30:25], instr_full[11:8], 1'b0};

    always_comb begin
        pred_pc = fetch_pc_q + 32'd4;
        if (instr_full[6:0] == OP_JAL)
            pred_pc = fetch_pc_q + j_off;
        else if (instr_full[6:0] == OP_BR && fq.pred_taken_in)
            pred_pc = fetch_pc_q + b_off;
    end

    always_comb begin
        state_d = state_q;
        if (rdy_in) begin
            if (redirect_in) begin
                state_d = S_IDLE;
            end else begin
                case (state_q)
                    S_IDLE:  if (can_start) state_d = S_REQ;
                    S_REQ:   if (byte_cnt_q == 2'd3) state_d = S_WAIT;
                    S_WAIT:  if (push) state_d = S_IDLE;
                    default: state_d = S_IDLE;
                endcase
            end
        end
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state_q     <= S_IDLE;
            fetch_pc_q  <= RESET_PC;
            byte_cnt_q  <= 2'd0;
            rcv_cnt_q   <= 2'd0;
            instr_buf_q <= 24'd0;
            discard_q   <= 1'b0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
        end else if (rdy_in) begin
            state_q <= state_d;
            if (redirect_in) begin
                fetch_pc_q <= redirect_pc_in;
                byte_cnt_q <= 2'd0;
                rcv_cnt_q  <= 2'd0;
                discard_q  <= mem_req;
                wr_ptr_q   <= '0;
                rd_ptr_q   <= '0;
                count_q    <= '0;
            end else begin
                if (mem_req) byte_cnt_q <= byte_cnt_q + 2'd1;
                if (fq.mem_valid_in && discard_q) discard_q <= 1'b0;
                if (byte_take) begin
                    rcv_cnt_q <= rcv_cnt_q + 2'd1;
                    case (rcv_cnt_q)
                        2'd0:    instr_buf_q[7:0]   <= fq.mem_din_in;
                        2'd1:    instr_buf_q[15:8]  <= fq.mem_din_in;
                        2'd2:    instr_buf_q[23:16] <= fq.mem_din_in;
                        default: fetch_pc_q         <= pred_pc;
                    endcase
                end
                if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
                if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
                count_q <= count_q + CW'(push) - CW'(pop);
            end
        end
    end

    // Entry storage needs no reset: only slots below count are ever observed.
    always_ff @(posedge clk_in) begin
        if (push) fifo_mem[wr_ptr_q] <= {instr_full, fetch_pc_q, pred_pc};
    end

    assign head               = fifo_mem[rd_ptr_q];
    assign fq.deq_valid_out   = deq_valid;
    assign fq.deq_instr_out   = deq_valid ? head[95:64] : 32'd0;
    assign fq.deq_pc_out      = deq_valid ? head[63:32] : 32'd0;
    assign fq.deq_pred_pc_out = deq_valid ? head[31:0]  : 32'd0;
    assign fq.count_out       = count_q;
    assign fq.mem_req_out     = mem_req;
    assign fq.mem_addr_out    = fetch_pc_q + {30'd0, byte_cnt_q};
    assign fq.pred_pc_req_out = fetch_pc_q;

`ifdef FETCH_PERF_EN
    logic stall_cycle;
    assign stall_cycle = rdy_in && !redirect_in && (state_q == S_IDLE) && !can_start;

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            perf_fetched_out <= 32'd0;
            perf_flush_out   <= 32'd0;
            perf_stall_out   <= 32'd0;
        end else if (rdy_in) begin
            if (push && perf_fetched_out != '1) perf_fetched_out <= perf_fetched_out + 32'd1;
            if (redirect_in && perf_flush_out != '1) perf_flush_out <= perf_flush_out + 32'd1;
            if (stall_cycle && perf_stall_out != '1) perf_stall_out <= perf_stall_out + 32'd1;
        end
    end
`endif
endmodule
